// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among four byte requesters.
//               Round-robin grant per byte, locked to one requester until
//               it flags the last byte of a message, optional idle gap
//               after each frame, and a watchdog that aborts a transmitter
//               that never reports done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [3:0]  i_Req_Valid,
  input  logic [31:0] i_Req_Byte,
  input  logic [3:0]  i_Req_Last,
  output logic [3:0]  o_Req_Ready,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Done,
  output logic [3:0]  o_Grant,
  output logic        o_Busy,
  output logic        o_Error
);

  // Counters run 0..N-1, so they only need to hold N-1 and never wrap.
  localparam int c_TO_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int c_GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int c_TO_L   = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;
  localparam int c_GAP_L  = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TO_L);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_L);

  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_WAIT_DONE = 2'd1;
  localparam logic [1:0] c_ST_GAP       = 2'd2;

  logic [1:0]         r_state;
  logic               r_lock;
  logic [1:0]         r_owner;
  logic [1:0]         r_last_grant;
  logic               r_tx_dv;
  logic [7:0]         r_tx_byte;
  logic               r_error;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;

  logic               w_sel_found;
  logic [1:0]         w_sel_id;
  logic               w_accept;

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Pick the next requester: the locked owner only, else round-robin after last grant.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = 2'd0;
    if (r_lock) begin
      w_sel_id    = r_owner;
      w_sel_found = i_Req_Valid[r_owner];
    end else begin
      for (int i = 1; i <= 4; i++) begin
        if (!w_sel_found && i_Req_Valid[r_last_grant + 2'(i)]) begin
          w_sel_found = 1'b1;
          w_sel_id    = r_last_grant + 2'(i);
        end
      end
    end
  end

  assign w_accept    = (r_state == c_ST_IDLE) && w_sel_found;
  assign o_Req_Ready = w_accept ? onehot(w_sel_id) : 4'b0000;

  // Arbitration state, launch strobe, watchdog and gap timing.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state      <= c_ST_IDLE;
      r_lock       <= 1'b0;
      r_owner      <= 2'd0;
      r_last_grant <= 2'd3;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_error      <= 1'b0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_tx_dv <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_tx_byte    <= i_Req_Byte[8*w_sel_id +: 8];
            r_tx_dv      <= 1'b1;
            r_last_grant <= w_sel_id;
            r_owner      <= w_sel_id;
            r_lock       <= ~i_Req_Last[w_sel_id];
            r_to_cnt     <= '0;
            r_state      <= c_ST_WAIT_DONE;
          end
        end
        c_ST_WAIT_DONE: begin
          // Done wins over a timeout landing in the same cycle.
          if (i_TX_Done) begin
            r_to_cnt <= '0;
            if (GAP_CLKS > 0) begin
              r_gap_cnt <= '0;
              r_state   <= c_ST_GAP;
            end else begin
              r_state <= c_ST_IDLE;
            end
          end else if (r_to_cnt == c_TO_LAST) begin
            r_error  <= 1'b1;
            r_lock   <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= c_ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= c_ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Owner is shown while a frame is in flight, and while a message holds the lock.
  always_comb begin
    o_Grant = 4'b0000;
    if (r_state != c_ST_IDLE) begin
      o_Grant = onehot(r_owner);
    end else if (r_lock) begin
      o_Grant = onehot(r_owner);
    end
  end

  assign o_TX_DV   = r_tx_dv;
  assign o_TX_Byte = r_tx_byte;
  assign o_Busy    = (r_state != c_ST_IDLE);
  assign o_Error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter. Instance a runs with no
//               gap and a 16-clock watchdog, instance b with a 5-clock gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] bytes;
  logic [3:0]  last;
  logic        done_a, done_b;

  logic [3:0]  ready_a, grant_a, ready_b, grant_b;
  logic        dv_a, busy_a, err_a, dv_b, busy_b, err_b;
  logic [7:0]  byte_a, byte_b;

  int n_total;
  int n_bad;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP_CLKS(0), .TIMEOUT_CLKS(16)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Req_Valid(valid), .i_Req_Byte(bytes),
    .i_Req_Last(last), .o_Req_Ready(ready_a), .o_TX_DV(dv_a), .o_TX_Byte(byte_a),
    .i_TX_Done(done_a), .o_Grant(grant_a), .o_Busy(busy_a), .o_Error(err_a)
  );

  uart_tx_arbiter #(.GAP_CLKS(5), .TIMEOUT_CLKS(4096)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Req_Valid(valid), .i_Req_Byte(bytes),
    .i_Req_Last(last), .o_Req_Ready(ready_b), .o_TX_DV(dv_b), .o_TX_Byte(byte_b),
    .i_TX_Done(done_b), .o_Grant(grant_b), .o_Busy(busy_b), .o_Error(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    valid  = 4'b0000;
    done_a = 1'b0;
    done_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    valid   = 4'b0000;
    bytes   = 32'h0;
    last    = 4'b0000;
    done_a  = 1'b0;
    done_b  = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_dv",    dv_a,    0);
    chk("rst_byte",  byte_a,  0);
    chk("rst_grant", grant_a, 0);
    chk("rst_busy",  busy_a,  0);
    chk("rst_err",   err_a,   0);
    chk("rst_ready", ready_a, 0);
    rst_n = 1'b1;
    step();

    // two requesters, req0 first after reset, then req2
    valid = 4'b0101; bytes = 32'h0043_0041; last = 4'b1111;
    at_neg(); chk("t30_rdy0", ready_a, 4'b0001);
    step(); valid = 4'b0100;
    at_neg();
    chk("t30_dv0",    dv_a,    1);
    chk("t30_byte0",  byte_a,  8'h41);
    chk("t30_grant0", grant_a, 4'b0001);
    chk("t30_busy",   busy_a,  1);
    chk("t30_nordy",  ready_a, 0);
    step(); done_a = 1'b1;
    at_neg();
    chk("t30_dvonce", dv_a,   0);
    chk("t30_hold",   byte_a, 8'h41);
    step(); done_a = 1'b0;
    at_neg();
    chk("t30_rdy2",  ready_a, 4'b0100);
    chk("t30_idle",  busy_a,  0);
    chk("t30_gidle", grant_a, 0);
    step(); valid = 4'b0000;
    at_neg();
    chk("t30_dv2",    dv_a,    1);
    chk("t30_byte2",  byte_a,  8'h43);
    chk("t30_grant2", grant_a, 4'b0100);
    done_a = 1'b1; step(); done_a = 1'b0;

    // all four valid, round-robin 0,1,2,3,0
    do_reset();
    valid = 4'b1111; bytes = 32'hA3A2_A1A0; last = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] e_rdy;
      logic [7:0] e_byte;
      e_rdy  = 4'b0001 << (i % 4);
      e_byte = 8'hA0 + 8'(i % 4);
      at_neg(); chk("t31_rdy", ready_a, e_rdy);
      step();
      at_neg();
      chk("t31_dv",   dv_a,   1);
      chk("t31_byte", byte_a, e_byte);
      done_a = 1'b1; step(); done_a = 1'b0;
    end
    valid = 4'b0000;

    // locked message from req1 while req0 and req3 compete
    do_reset();
    valid = 4'b0001; bytes = 32'h3322_1050; last = 4'b1111;
    at_neg(); chk("t32_pre_rdy", ready_a, 4'b0001);
    step(); valid = 4'b0000;
    at_neg(); chk("t32_pre_byte", byte_a, 8'h50);
    done_a = 1'b1; step(); done_a = 1'b0;
    valid = 4'b1011; last = 4'b1101;
    at_neg(); chk("t32_r1a", ready_a, 4'b0010);
    step(); bytes[15:8] = 8'h11;
    at_neg();
    chk("t32_b10", byte_a,  8'h10);
    chk("t32_g1",  grant_a, 4'b0010);
    done_a = 1'b1; step(); done_a = 1'b0;
    at_neg();
    chk("t32_lockgrant", grant_a, 4'b0010);
    chk("t32_r1b",       ready_a, 4'b0010);
    step(); bytes[15:8] = 8'h12; last = 4'b1111;
    at_neg(); chk("t32_b11", byte_a, 8'h11);
    done_a = 1'b1; step(); done_a = 1'b0;
    at_neg(); chk("t32_r1c", ready_a, 4'b0010);
    step(); valid = 4'b1001;
    at_neg(); chk("t32_b12", byte_a, 8'h12);
    done_a = 1'b1; step(); done_a = 1'b0;
    at_neg();
    chk("t32_rr3",    ready_a, 4'b1000);
    chk("t32_unlock", grant_a, 4'b0000);
    step(); valid = 4'b0000;
    at_neg(); chk("t32_b33", byte_a, 8'h33);
    done_a = 1'b1; step(); done_a = 1'b0;

    // watchdog: abort after 16 waiting cycles, then done exactly at 16
    do_reset();
    valid = 4'b0001; bytes = 32'h0000_6655; last = 4'b0000;
    at_neg(); chk("t34_rdy", ready_a, 4'b0001);
    step(); valid = 4'b0000;
    at_neg(); chk("t34_dv", dv_a, 1);
    repeat (15) step();
    at_neg();
    chk("t34_pre_err",  err_a,   0);
    chk("t34_pre_busy", busy_a,  1);
    chk("t34_pre_gnt",  grant_a, 4'b0001);
    valid = 4'b0010;
    step();
    at_neg();
    chk("t34_err",    err_a,   1);
    chk("t34_idle",   busy_a,  0);
    chk("t34_nolock", grant_a, 0);
    chk("t34_rdy1",   ready_a, 4'b0010);
    step(); valid = 4'b0000;
    at_neg();
    chk("t34_errpulse", err_a,  0);
    chk("t34_dv1",      dv_a,   1);
    chk("t34_byte1",    byte_a, 8'h66);
    repeat (15) step();
    done_a = 1'b1;
    at_neg(); chk("t34_d16_pre", err_a, 0);
    step(); done_a = 1'b0;
    at_neg();
    chk("t34_done16", err_a,  0);
    chk("t34_d16idl", busy_a, 0);
    step();
    at_neg(); chk("t34_d16_post", err_a, 0);

    // asynchronous reset during WAIT_DONE
    do_reset();
    valid = 4'b0001; bytes = 32'h0000_0077; last = 4'b1111;
    at_neg(); chk("t35_rdy", ready_a, 4'b0001);
    step(); valid = 4'b0000;
    at_neg(); chk("t35_busy", busy_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t35_dv",    dv_a,    0);
    chk("t35_byte",  byte_a,  0);
    chk("t35_rbusy", busy_a,  0);
    chk("t35_grant", grant_a, 0);
    chk("t35_err",   err_a,   0);
    @(posedge clk); #1;
    rst_n = 1'b1; valid = 4'b0101;
    at_neg(); chk("t35_req0", ready_a, 4'b0001);
    step(); valid = 4'b0000;
    at_neg(); chk("t35_b77", byte_a, 8'h77);
    done_a = 1'b1; step(); done_a = 1'b0;

    // 5-clock gap after done before the next ready
    do_reset();
    valid = 4'b0001; bytes = 32'h0000_0088; last = 4'b1111;
    at_neg(); chk("t33_rdy", ready_b, 4'b0001);
    step();
    at_neg(); chk("t33_dv", dv_b, 1);
    done_b = 1'b1; step(); done_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t33_gap_rdy",  ready_b, 0);
      chk("t33_gap_busy", busy_b,  1);
      chk("t33_gap_gnt",  grant_b, 4'b0001);
      step();
    end
    at_neg();
    chk("t33_rdy_after", ready_b, 4'b0001);
    chk("t33_idle",      busy_b,  0);
    valid = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
